core_exec_operand_stage: RTL and testbench

Registered operand-selection stage between decode and the execute units. Chooses `src_a`/`src_b` per `exec_src`, forwards in-flight results over the register-file values, and holds the last memory read datum for read-modify-write (AMO) sequences. Output is a valid/ready pipeline register, so decode and execute decouple. Generalised over data width and number of forwarding ports.

---
 rtl/core_pkg.sv | 15 +
 rtl/core_exec_fwd_mux.sv | 28 ++
 rtl/core_exec_operand_stage.sv | 110 +++++++++++
 tb/tb_core_exec_operand_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the execute-side operand path.
// Source-mode encoding and register index width.
package core_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    SRC_RR = 3'd0,
    SRC_RI = 3'd1,
    SRC_PI = 3'd2,
    SRC_ZI = 3'd3,
    SRC_MR = 3'd4
  } exec_src_e;

endpackage

// File: rtl/core_exec_fwd_mux.sv
// Priority forwarding match for one source register.
// Ports: rs, reg_value in; fwd_valid/fwd_rd/fwd_data in; value out.
module core_exec_fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_IDX_W-1:0]               rs,
  input  logic [XLEN-1:0]                    reg_value,
  input  logic [NUM_FWD-1:0]                 fwd_valid,
  input  logic [NUM_FWD-1:0][REG_IDX_W-1:0]  fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]       fwd_data,
  output logic [XLEN-1:0]                    value
);

  // Walk from oldest to youngest so the lowest index wins.
  always_comb begin
    value = reg_value;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && fwd_rd[i] == rs)
        value = fwd_data[i];
    end
    if (rs == '0)
      value = '0;
  end

endmodule

// File: rtl/core_exec_operand_stage.sv
// Operand select + forwarding + AMO rdata holder, valid/ready output reg.
// Ports: decode side in_*, fwd_*, mem_r*; execute side out_*, src_a/src_b.
module core_exec_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  exec_src_e                          exec_src,
  input  logic [REG_IDX_W-1:0]               rs1,
  input  logic [REG_IDX_W-1:0]               rs2,
  input  logic [XLEN-1:0]                    reg_a_value,
  input  logic [XLEN-1:0]                    reg_b_value,
  input  logic [XLEN-1:0]                    imm_val,
  input  logic [XLEN-1:0]                    pc,
  input  logic                               mem_rvalid,
  input  logic [XLEN-1:0]                    mem_rdata,
  input  logic [NUM_FWD-1:0]                 fwd_valid,
  input  logic [NUM_FWD-1:0][REG_IDX_W-1:0]  fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]       fwd_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [XLEN-1:0]                    src_a,
  output logic [XLEN-1:0]                    src_b,
  output logic                               out_illegal
);

  logic [XLEN-1:0] a_fwd, b_fwd;
  logic [XLEN-1:0] last_rdata;
  logic            lr_full;
  logic [XLEN-1:0] sel_a, sel_b, mr_a;
  logic            sel_ill;
  logic            is_mr, mr_stall, accept;

  core_exec_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_a (
    .rs        (rs1),
    .reg_value (reg_a_value),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .value     (a_fwd)
  );

  core_exec_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd_b (
    .rs        (rs2),
    .reg_value (reg_b_value),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .value     (b_fwd)
  );

  assign is_mr    = (exec_src == SRC_MR);
  assign mr_stall = is_mr && !lr_full && !mem_rvalid;
  assign in_ready = (!out_valid || out_ready) && !mr_stall;
  assign accept   = in_valid && in_ready;

  // Same-cycle read data bypasses the holder.
  assign mr_a = mem_rvalid ? mem_rdata : last_rdata;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_ill = 1'b0;
    case (exec_src)
      SRC_RR: begin sel_a = a_fwd;  sel_b = b_fwd;   end
      SRC_RI: begin sel_a = a_fwd;  sel_b = imm_val; end
      SRC_PI: begin sel_a = pc;     sel_b = imm_val; end
      SRC_ZI: begin sel_a = '0;     sel_b = imm_val; end
      SRC_MR: begin sel_a = mr_a;   sel_b = b_fwd;   end
      default: sel_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_rdata <= '0;
      lr_full    <= 1'b0;
    end else begin
      if (mem_rvalid)
        last_rdata <= mem_rdata;
      // An accepted MR consumes the datum, bypassed or held.
      if (accept && is_mr)
        lr_full <= 1'b0;
      else if (mem_rvalid)
        lr_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      src_a       <= '0;
      src_b       <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      src_a       <= sel_a;
      src_b       <= sel_b;
      out_illegal <= sel_ill;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_exec_operand_stage.sv
// Directed bench for core_exec_operand_stage.
// Hand-computed vectors; one check task; summary line at end.
module tb_core_exec_operand_stage;
  import core_pkg::*;

  localparam int XLEN = 32;
  localparam int NF   = 2;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  exec_src_e exec_src;
  logic [4:0] rs1, rs2;
  logic [XLEN-1:0] reg_a_value, reg_b_value, imm_val, pc;
  logic mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic [NF-1:0] fwd_valid;
  logic [NF-1:0][4:0] fwd_rd;
  logic [NF-1:0][XLEN-1:0] fwd_data;
  logic out_valid, out_ready;
  logic [XLEN-1:0] src_a, src_b;
  logic out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_exec_operand_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .exec_src    (exec_src),
    .rs1         (rs1),
    .rs2         (rs2),
    .reg_a_value (reg_a_value),
    .reg_b_value (reg_b_value),
    .imm_val     (imm_val),
    .pc          (pc),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_illegal (out_illegal)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    exec_src = SRC_RR;
    rs1 = '0; rs2 = '0;
    reg_a_value = '0; reg_b_value = '0;
    imm_val = '0; pc = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    fwd_valid = '0; fwd_rd = '0; fwd_data = '0;
    out_ready = 1'b1;

    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_a", src_a, 32'h0);
    check("rst_b", src_b, 32'h0);
    check("rst_ill", 32'(out_illegal), 32'd0);
    rst = 1'b0;
    tick();

    // RI, no forwarding
    in_valid = 1'b1; exec_src = SRC_RI;
    rs1 = 5'd3; reg_a_value = 32'h10; imm_val = 32'h4;
    #1 check("ri_ready", 32'(in_ready), 32'd1);
    tick();
    check("ri_valid", 32'(out_valid), 32'd1);
    check("ri_a", src_a, 32'h10);
    check("ri_b", src_b, 32'h4);

    // RR, both ports hit: youngest wins
    exec_src = SRC_RR; rs1 = 5'd5; rs2 = 5'd5;
    reg_a_value = 32'h11; reg_b_value = 32'h22;
    fwd_valid = 2'b11; fwd_rd[0] = 5'd5; fwd_rd[1] = 5'd5;
    fwd_data[0] = 32'hAA; fwd_data[1] = 32'hBB;
    tick();
    check("fwd_pri_a", src_a, 32'hAA);
    check("fwd_pri_b", src_b, 32'hAA);

    // only older port valid; rs2 misses
    fwd_valid = 2'b10; rs2 = 5'd6;
    tick();
    check("fwd1_a", src_a, 32'hBB);
    check("fwd_miss_b", src_b, 32'h22);

    // x0 never forwarded
    rs1 = 5'd0; rs2 = 5'd5; reg_a_value = 32'h77;
    fwd_valid = 2'b01; fwd_rd[0] = 5'd0; fwd_data[0] = 32'hFF;
    tick();
    check("x0_a", src_a, 32'h0);
    check("x0_b", src_b, 32'h22);
    fwd_valid = '0;

    // PI and ZI
    exec_src = SRC_PI; pc = 32'h1000; imm_val = 32'h8;
    tick();
    check("pi_a", src_a, 32'h1000);
    check("pi_b", src_b, 32'h8);
    exec_src = SRC_ZI; imm_val = 32'h9; rs1 = 5'd3;
    tick();
    check("zi_a", src_a, 32'h0);
    check("zi_b", src_b, 32'h9);

    // MR with nothing held: stall, then same-cycle bypass
    exec_src = SRC_MR; rs2 = 5'd7; reg_b_value = 32'h55;
    #1 check("mr_stall_rdy", 32'(in_ready), 32'd0);
    tick();
    check("mr_stall_valid", 32'(out_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234;
    #1 check("mr_byp_rdy", 32'(in_ready), 32'd1);
    tick();
    check("mr_byp_valid", 32'(out_valid), 32'd1);
    check("mr_byp_a", src_a, 32'h1234);
    check("mr_byp_b", src_b, 32'h55);
    mem_rvalid = 1'b0;
    #1 check("mr_lr_empty", 32'(in_ready), 32'd0);

    // held datum, newer read overwrites older
    in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
    tick();
    mem_rdata = 32'hBEEF;
    tick();
    mem_rvalid = 1'b0; in_valid = 1'b1;
    #1 check("mr_held_rdy", 32'(in_ready), 32'd1);
    tick();
    check("mr_held_a", src_a, 32'hBEEF);

    // rdata during non-MR accept: output unaffected, datum kept
    exec_src = SRC_RI; rs1 = 5'd3; reg_a_value = 32'h31; imm_val = 32'h2;
    mem_rvalid = 1'b1; mem_rdata = 32'hC0DE;
    tick();
    check("nonmr_a", src_a, 32'h31);
    check("nonmr_b", src_b, 32'h2);
    mem_rvalid = 1'b0; exec_src = SRC_MR;
    tick();
    check("mr_later_a", src_a, 32'hC0DE);

    // back-pressure: drain then stall 3 cycles
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; exec_src = SRC_RI;
    rs1 = 5'd1; reg_a_value = 32'hA1; imm_val = 32'h101;
    tick();
    check("bp_first_b", src_b, 32'h101);
    reg_a_value = 32'hA2; imm_val = 32'h102;
    for (int i = 0; i < 3; i++) begin
      check("bp_rdy", 32'(in_ready), 32'd0);
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_a", src_a, 32'hA1);
      check("bp_b", src_b, 32'h101);
    end
    out_ready = 1'b1;
    #1 check("bp_rel_rdy", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_a", src_a, 32'hA2);
    check("bp_next_b", src_b, 32'h102);
    in_valid = 1'b0;
    tick();
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // illegal encoding
    in_valid = 1'b1; exec_src = exec_src_e'(3'd6);
    tick();
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_a", src_a, 32'h0);
    check("ill_b", src_b, 32'h0);
    check("ill_flag", 32'(out_illegal), 32'd1);
    exec_src = SRC_RI;
    tick();
    check("ill_clear", 32'(out_illegal), 32'd0);

    // reset in the middle of a stall with pending rdata
    out_ready = 1'b0; in_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h9999;
    tick();
    mem_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_a", src_a, 32'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; exec_src = SRC_MR;
    #1 check("rst_mid_lr", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
